// File: rtl/led_duty_pwm.sv
// Eight-channel LED brightness PWM with shadowed duty registers.
// Duty writes land in the shadow set and become active only at a frame boundary.
module led_duty_pwm #(
  parameter int unsigned PRESC_DIV = 196,
  parameter logic [7:0]  LED_POL   = 8'h00
) (
  input  logic       CLK50M,
  input  logic       RESET,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [2:0] WR_CH,
  input  logic       WR_ALL,
  input  logic [7:0] WR_DUTY,
  output logic [7:0] LED,
  output logic       FRAME_START
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESC_DIV - 1);

  logic [15:0] presc;
  logic [7:0]  pwm_cnt;
  logic [7:0]  shadow [8];
  logic [7:0]  active [8];

  logic       tick;
  logic       frame_end;
  logic       wr_fire;
  logic [7:0] led_next;

  always_comb begin
    // NOTE: every signal gets a default before any conditional logic, so no latch is inferred.
    tick      = (presc == PRESC_MAX);
    frame_end = tick && (pwm_cnt == 8'hFF);
    wr_fire   = WR_VALID && WR_READY;
    led_next  = LED_POL;
    for (int i = 0; i < 8; i++) begin
      led_next[i] = (pwm_cnt < active[i]) ^ LED_POL[i];
    end
  end

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      presc       <= '0;
      pwm_cnt     <= '0;
      LED         <= LED_POL;
      FRAME_START <= 1'b0;
      WR_READY    <= 1'b0;
      // NOTE: the duty sets are a handful of flops, not a RAM, so they are cleared like any other state.
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      WR_READY    <= 1'b1;
      presc       <= tick ? '0 : presc + 16'd1;
      FRAME_START <= frame_end;
      LED         <= led_next;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      // NOTE: non-blocking assignment makes active capture the pre-write shadow when a
      // write coincides with the frame boundary; the new value waits one more frame.
      for (int i = 0; i < 8; i++) begin
        if (frame_end) begin
          active[i] <= shadow[i];
        end
        if (wr_fire && (WR_ALL || WR_CH == 3'(i))) begin
          shadow[i] <= WR_DUTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_duty_pwm.sv
// Directed bench for led_duty_pwm at PRESC_DIV=2 (frame = 512 cycles), LED_POL=0.
module tb_led_duty_pwm;

  localparam int FRAME = 512;

  logic       CLK50M = 1'b0;
  logic       RESET  = 1'b1;
  logic       WR_VALID = 1'b0;
  logic       WR_READY;
  logic [2:0] WR_CH = '0;
  logic       WR_ALL = 1'b0;
  logic [7:0] WR_DUTY = '0;
  logic [7:0] LED;
  logic       FRAME_START;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         at;
    logic [2:0] ch;
    logic       all;
    logic [7:0] duty;
  } wr_t;

  wr_t        pend [$];
  logic [7:0] exp_shadow [8];
  logic [7:0] exp_active [8];

  led_duty_pwm #(.PRESC_DIV(2), .LED_POL(8'h00)) dut (
    .CLK50M      (CLK50M),
    .RESET       (RESET),
    .WR_VALID    (WR_VALID),
    .WR_READY    (WR_READY),
    .WR_CH       (WR_CH),
    .WR_ALL      (WR_ALL),
    .WR_DUTY     (WR_DUTY),
    .LED         (LED),
    .FRAME_START (FRAME_START)
  );

  always #10 CLK50M = ~CLK50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic queue_wr(input int at, input logic [2:0] ch, input logic all,
                          input logic [7:0] duty);
    wr_t w;
    w.at = at; w.ch = ch; w.all = all; w.duty = duty;
    pend.push_back(w);
  endtask

  // Reset for n cycles, release, then wait for the first frame pulse (expected 512 cycles on).
  task automatic do_reset(input string tag, input int n);
    int cnt;
    int led_bad;
    @(negedge CLK50M);
    RESET = 1'b1;
    repeat (n) begin
      @(negedge CLK50M);
      check({tag, "_rst_led"}, LED, 8'h00);
      check({tag, "_rst_fs"}, FRAME_START, 0);
      check({tag, "_rst_rdy"}, WR_READY, 0);
    end
    RESET = 1'b0;
    @(negedge CLK50M);
    check({tag, "_rdy_after"}, WR_READY, 1);
    WR_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_shadow[i] = '0;
      exp_active[i] = '0;
    end
    cnt = 1;
    led_bad = 0;
    while (!FRAME_START && cnt < 1000) begin
      @(negedge CLK50M);
      cnt++;
      if (LED !== 8'h00) led_bad++;
    end
    check({tag, "_first_frame"}, cnt, FRAME);
    check({tag, "_startup_led"}, led_bad, 0);
  endtask

  // Observe one full frame from the cycle after a boundary through the next boundary,
  // applying any queued writes at their sample index.
  task automatic run_frame(input string tag);
    logic [7:0] snap [8];
    logic [7:0] exp_led;
    int         hi [8];
    int         mism;
    snap = exp_shadow;
    mism = 0;
    for (int i = 0; i < 8; i++) hi[i] = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge CLK50M);
      for (int i = 0; i < 8; i++) begin
        exp_led[i] = (k < 2 * int'(exp_active[i]));
        if (LED[i] === 1'b1) hi[i]++;
      end
      if (LED !== exp_led) mism++;
      if (k < FRAME - 1 && FRAME_START !== 1'b0) mism++;
      if (k == FRAME - 1) check({tag, "_fs"}, FRAME_START, 1);
      if (k == FRAME - 2) snap = exp_shadow;
      WR_VALID = 1'b0;
      foreach (pend[j]) begin
        if (pend[j].at == k) begin
          WR_VALID = 1'b1;
          WR_CH    = pend[j].ch;
          WR_ALL   = pend[j].all;
          WR_DUTY  = pend[j].duty;
          for (int i = 0; i < 8; i++) begin
            if (pend[j].all || pend[j].ch == 3'(i)) exp_shadow[i] = pend[j].duty;
          end
        end
      end
    end
    WR_VALID = 1'b0;
    pend.delete();
    check({tag, "_shape"}, mism, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_hi%0d", tag, i), hi[i], 2 * int'(exp_active[i]));
    end
    exp_active = snap;
  endtask

  initial begin
    // Startup, with a write held across reset and the release edge that must be ignored.
    WR_VALID = 1'b1;
    WR_ALL   = 1'b1;
    WR_DUTY  = 8'hFF;
    do_reset("t1", 3);
    WR_ALL = 1'b0;
    run_frame("t1_idle");

    queue_wr(100, 3'd3, 1'b0, 8'd64);
    run_frame("t2_defer");
    run_frame("t2_apply");

    queue_wr(10, 3'd0, 1'b0, 8'd0);
    queue_wr(20, 3'd7, 1'b0, 8'd255);
    run_frame("t3_load");
    run_frame("t3_ext");

    queue_wr(50, 3'd5, 1'b1, 8'd128);
    run_frame("t4_load");
    run_frame("t4_bcast");

    queue_wr(FRAME - 2, 3'd1, 1'b0, 8'd200);
    run_frame("t5a_coll");
    run_frame("t5a_old");
    run_frame("t5a_new");

    queue_wr(30, 3'd2, 1'b0, 8'd10);
    queue_wr(31, 3'd2, 1'b0, 8'd50);
    run_frame("t5b_load");
    run_frame("t5b_last");

    queue_wr(5, 3'd0, 1'b1, 8'hFF);
    run_frame("t6_load");
    run_frame("t6_full");
    repeat (FRAME / 2) @(negedge CLK50M);
    do_reset("t6", 1);
    run_frame("t6_post1");
    run_frame("t6_post2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_duty_pwm.md
Name: led_duty_pwm

Overview:
8-channel LED brightness PWM stage driving the DE0-Nano LED[7:0] pins from per-channel 8-bit duty values. An upstream pattern or control block writes the duty values over a valid/ready port. Writes go to shadow registers, which are copied to the active set only at a PWM frame boundary, so the LEDs never glitch mid-frame. It replaces free-running single-pattern PWM with per-channel, software-set brightness.

Parameters:
PRESC_DIV, 196, CLK50M cycles per PWM tick (range 1..65535); frame = 256 ticks (≈996 Hz at default).
LED_POL, 8'h00, per-channel output polarity; bit i = 1 inverts LED[i].

Ports:
CLK50M  in  1  system clock, 50 MHz; all logic on its rising edge.
RESET  in  1  reset, synchronous and active-high.
WR_VALID  in  1  duty write request.
WR_READY  out  1  block can accept a write.
WR_CH  in  3  target channel index 0..7.
WR_ALL  in  1  broadcast: write WR_DUTY to all 8 channels, ignore WR_CH.
WR_DUTY  in  8  duty value; on-time = WR_DUTY/256 of frame.
LED  out  8  PWM outputs to board LEDs.
FRAME_START  out  1  one-cycle pulse after each frame boundary.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - Shadow duty, active duty, prescaler and pwm_cnt all cleared to 0.
  - LED <= LED_POL (all channels off), FRAME_START <= 0, WR_READY <= 0.
- WR_READY is 0 in every cycle that follows a reset edge. It is 1 from the first cycle after RESET is sampled low, and stays 1 until the next reset.
- Write handshake:
  - Accept when WR_VALID && WR_READY at a clock edge; at most one write per cycle.
  - Accepted write updates shadow[WR_CH], or all shadows if WR_ALL=1, on that edge.
  - WR_CH is don't-care when WR_ALL=1.
  - WR_VALID while WR_READY=0 is ignored; no queueing.
- Prescaler:
  - Counts 0..PRESC_DIV-1 and wraps.
  - tick = (prescaler == PRESC_DIV-1). PRESC_DIV=1 gives tick every cycle.
- pwm_cnt:
  - 8-bit; increments on tick; wraps 255 -> 0.
  - Frame boundary = tick && pwm_cnt==255.
- On the frame-boundary edge:
  - Active duty[0..7] <= shadow[0..7].
  - FRAME_START <= 1 for exactly one cycle.
- Write on the same edge as a frame boundary:
  - The active set captures the old shadow value.
  - The shadow takes the new value, which is applied from the following frame.
- Multiple writes to one channel within a frame: last accepted write wins.
- Output:
  - LED[i] <= (pwm_cnt < active[i]) XOR LED_POL[i], registered.
  - Latency is 1 cycle from pwm_cnt/active to LED.
  - Duty 0: never on. Duty 255: on 255 ticks, off 1 tick (pwm_cnt==255). Duty d: on for pwm_cnt 0..d-1.
  - All channels share pwm_cnt, so rising edges of on-channels align at pwm_cnt=0.
- Reset mid-frame: all state aborts on that edge with no frame completion or copy. After release, the first frame starts from pwm_cnt=0.
- No combinational path from inputs to outputs.

Test Plan:
(All with PRESC_DIV=2, LED_POL=0: tick every 2 cycles, frame = 512 cycles.)
1. Reset and startup:
   - Stimulus: hold RESET 3 cycles, then release.
   - Required: LED=8'h00, FRAME_START=0 and WR_READY=0 during reset; WR_READY=1 the cycle after release.
   - Required: first FRAME_START pulse 512 cycles after release; LED stays 0 throughout (all duties 0).
2. Deferred update:
   - Stimulus: write ch3 duty 64 at cycle 100 of a frame.
   - Required: LED[3] stays 0 for the rest of that frame.
   - Required: from the next frame, LED[3] high for 128 cycles, then low 384 cycles, per frame; other LEDs stay 0.
3. Duty extremes:
   - Stimulus: ch0 = 0, ch7 = 255.
   - Required: LED[0] never high.
   - Required: LED[7] low for exactly 2 cycles per frame, at pwm_cnt=255, one cycle delayed.
4. Broadcast:
   - Stimulus: WR_ALL=1, WR_DUTY=128.
   - Required: next frame, all 8 LEDs high 256 cycles, low 256 cycles, with identical edge timing.
   - Required: WR_CH value has no effect.
5. Boundary collision and last-wins:
   - Stimulus A: write ch1 = 200 on the frame-boundary edge.
     Required: the frame just starting uses the old ch1 value; 200 applies in the frame after.
   - Stimulus B: write ch2 = 10, then ch2 = 50, within one frame.
     Required: next frame, LED[2] is high 100 cycles.
6. Mid-frame reset:
   - Stimulus: load duties 8'hFF on all channels, run 1.5 frames, pulse RESET for 1 cycle.
   - Required: LED=0 and FRAME_START=0 the next cycle; shadows cleared.
   - Required: after release, LEDs stay 0 through the next two frames with no further writes.
